button_frame_tx: RTL and testbench
==================================

// Module: button_frame_tx
// PURPOSE
//  Serialises one button byte onto a single-wire line for the controller's serial
//  button receiver. Idle line is high. A frame is a low start period, DATA_BITS data
//  bits MSB first, then a high stop/gap period.
//  Sits on the pad/emulator side, driven by the button sampler via a valid/ready handshake.
// PARAMETERS
//  DATA_BITS    8    data bits per frame
//  BIT_CYCLES   200  clk cycles per start bit and per data bit; must be >= 2
//  STOP_CYCLES  16   clk cycles of forced-high line after the last data bit; must be >= 10
//                    (receiver needs >= 10 high samples before a falling edge)
// PORTS
//  clk         in   1          system clock, all logic on rising edge
//  reset       in   1          synchronous, active-high
//  tx_valid    in   1          tx_data holds a frame to send
//  tx_data     in   DATA_BITS  button states, bit DATA_BITS-1 sent first
//  tx_ready    out  1          block accepts a frame this cycle
//  txline      out  1          serial line, registered, idle high
//  busy        out  1          frame in progress (START, DATA or STOP)
//  frame_done  out  1          one-cycle pulse, last stop cycle finished
// BEHAVIOUR
//  - Reset: on any edge with reset=1: state=IDLE, txline=1, frame_done=0, shift reg and
//    counters cleared. Aborts a frame in progress; line returns high on that edge.
//    tx_ready = (state==IDLE) & ~reset (combinational); busy = (state!=IDLE).
//  - FSM states IDLE, START, DATA, STOP; bit_cnt counts 0..BIT_CYCLES-1, with width
//    $clog2(max(BIT_CYCLES,STOP_CYCLES)); idx counts data bits.
//  - IDLE: txline=1. Accept when tx_valid & tx_ready at edge E: latch tx_data into shift
//    reg, txline<=0, bit_cnt<=0, go START. tx_data is ignored after E.
//  - START: txline low for exactly BIT_CYCLES cycles, beginning at E. On the edge where
//    bit_cnt==BIT_CYCLES-1: txline<=shift[MSB], go DATA, idx<=0, bit_cnt<=0.
//  - DATA: each bit held BIT_CYCLES cycles. At bit end: if idx==DATA_BITS-1, txline<=1,
//    go STOP, bit_cnt<=0; else shift left, txline<=next MSB, idx++.
//  - STOP: txline=1 for STOP_CYCLES cycles. On the edge where bit_cnt==STOP_CYCLES-1:
//    go IDLE, frame_done<=1 for one cycle.
//  - Frame timing: txline low from E for BIT_CYCLES; the whole frame occupies
//    (1+DATA_BITS)*BIT_CYCLES + STOP_CYCLES cycles. tx_ready is high on the first cycle
//    after that, coinciding with frame_done.
//  - Back-to-back: a valid held high is accepted on the first IDLE cycle. The minimum
//    high gap between frames is STOP_CYCLES+1 cycles, counted from the last data-bit
//    end to the next start.
//  - tx_valid while busy: ignored, no queuing, no error flag.
//  - All-ones data: the trailing high bits merge with STOP; the start falling edge still
//    occurs only after a full STOP. All-zeros data: line stays low from start through the
//    last bit, then rises.
//  - reset and tx_valid in the same cycle: reset wins; nothing is accepted.
//  - Counters never wrap: every count terminates at its compare value.
// TESTING
//  (bench: DATA_BITS=8, BIT_CYCLES=4, STOP_CYCLES=10)
//  1 reset then tx_data=8'hA5, valid 1 cycle -> txline: 4x0, then 1,0,1,0,0,1,0,1 each
//    4 cycles, then 10x1; frame_done pulses at cycle 46 after accept; tx_ready=1 same cycle.
//  2 valid held with 8'hFF then 8'h00 -> second start falls exactly 11 cycles after the
//    last 8'hFF data bit ends; line low 36 cycles during the 8'h00 frame.
//  3 change tx_data and toggle tx_valid mid-frame -> txline unaffected; tx_ready=0,
//    busy=1 throughout.
//  4 reset asserted in DATA bit 3 -> next cycle txline=1, busy=0, no frame_done; a new
//    8'h3C frame after reset is sent intact.
//  5 reset high with tx_valid=1 -> tx_ready=0, no accept; first accept on the cycle after
//    reset falls.
//  6 all 256 tx_data values sent through a receiver model -> every byte recovered;
//    >= 10 high cycles precede every falling start edge.

Source files
------------

// File: rtl/button_frame_tx.sv
// button_frame_tx
//   Serialises one button byte onto a single-wire line that idles high.
//   Frame: low start bit, DATA_BITS data bits MSB first, then a forced-high
//   stop/gap period long enough for the receiver to re-arm before the next
//   falling start edge. Frames are offered by the button sampler over a
//   valid/ready handshake; nothing is queued while a frame is in flight.
module button_frame_tx #(
    parameter int DATA_BITS   = 8,
    parameter int BIT_CYCLES  = 200,   // >= 2
    parameter int STOP_CYCLES = 16     // >= 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 txline,
    output logic                 busy,
    output logic                 frame_done
);

    // One counter serves start/data bits and the stop period, so it is sized
    // for whichever of the two is longer.
    localparam int CNT_MAX = (BIT_CYCLES > STOP_CYCLES) ? BIT_CYCLES : STOP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_nxt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_nxt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_nxt;
    logic                 txline_nxt;
    logic                 frame_done_nxt;

    logic accept;
    logic bit_end;
    logic stop_end;
    logic last_bit;

    // Handshake and terminal-count decodes shared by both combinational blocks.
    assign tx_ready = (state == IDLE) & ~reset;
    assign busy     = (state != IDLE);
    assign accept   = tx_valid & tx_ready;
    assign bit_end  = (bit_cnt == BIT_LAST);
    assign stop_end = (bit_cnt == STOP_LAST);
    assign last_bit = (idx == IDX_LAST);

    // State register plus the registered line, pulse, shifter and counters.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed by the combinational blocks.
    // NOTE: the shift register is reset too, so an aborted frame never leaks
    // stale data into later debug views; it holds no memory array.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            txline     <= 1'b1;
            frame_done <= 1'b0;
            shift_q    <= '0;
            bit_cnt    <= '0;
            idx        <= '0;
        end else begin
            state      <= state_nxt;
            txline     <= txline_nxt;
            frame_done <= frame_done_nxt;
            shift_q    <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            idx        <= idx_nxt;
        end
    end

    // Next-state: advance through the frame on each terminal count.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)                state_nxt = START;
            START:   if (bit_end)               state_nxt = DATA;
            DATA:    if (bit_end && last_bit)   state_nxt = STOP;
            STOP:    if (stop_end)              state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // Datapath next values: line level, shifter, bit/stop counter, bit index.
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    always_comb begin
        txline_nxt     = txline;
        shift_nxt      = shift_q;
        bit_cnt_nxt    = bit_cnt;
        idx_nxt        = idx;
        frame_done_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                txline_nxt  = 1'b1;
                bit_cnt_nxt = '0;
                idx_nxt     = '0;
                if (accept) begin
                    shift_nxt  = tx_data;
                    txline_nxt = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    txline_nxt  = shift_q[DATA_BITS-1];
                    idx_nxt     = '0;
                    bit_cnt_nxt = '0;
                end else begin
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_nxt = '0;
                    if (last_bit) begin
                        txline_nxt = 1'b1;
                    end else begin
                        shift_nxt  = shift_q << 1;
                        txline_nxt = shift_nxt[DATA_BITS-1];
                        idx_nxt    = idx + IDX_W'(1);
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                txline_nxt = 1'b1;
                if (stop_end) begin
                    bit_cnt_nxt    = '0;
                    frame_done_nxt = 1'b1;
                end else begin
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                txline_nxt  = 1'b1;
                bit_cnt_nxt = '0;
                idx_nxt     = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_frame_tx.sv
// tb_button_frame_tx
//   Directed bench for button_frame_tx with DATA_BITS=8, BIT_CYCLES=4,
//   STOP_CYCLES=10. Expected line levels come from a per-cycle frame model; a
//   line monitor measures edge timing and decodes bytes like the receiver.
module tb_button_frame_tx;

    localparam int DB   = 8;
    localparam int BC   = 4;
    localparam int SC   = 10;
    localparam int FLEN = (1 + DB) * BC + SC;   // 46 cycles per frame

    logic          clk;
    logic          reset;
    logic          tx_valid;
    logic [DB-1:0] tx_data;
    logic          tx_ready;
    logic          txline;
    logic          busy;
    logic          frame_done;

    int n_tests;
    int n_fail;
    int cyc;

    button_frame_tx #(
        .DATA_BITS  (DB),
        .BIT_CYCLES (BC),
        .STOP_CYCLES(SC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .txline    (txline),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level k cycles after the accepting edge.
    function automatic logic exp_line(input logic [DB-1:0] b, input int k);
        if (k < BC)            return 1'b0;
        if (k < (1 + DB) * BC) return b[DB - 1 - (k - BC) / BC];
        return 1'b1;
    endfunction

    // Line monitor: edge timestamps, high-run length, receiver model.
    logic          prev_line;
    int            run;
    int            fall_cyc;
    int            rise_cyc;
    logic          gap_chk;
    logic          rx_active;
    int            rx_cnt;
    int            rx_bits;
    logic [DB-1:0] rx_shreg;
    logic [DB-1:0] rx_last;
    int            rx_n;

    always @(negedge clk) begin
        if (reset) begin
            prev_line = 1'b1;
            run       = 0;
            rx_active = 1'b0;
        end else begin
            if (!rx_active && prev_line && !txline) begin
                fall_cyc = cyc;
                if (gap_chk) check("start_gap_ge10", 32'(run >= SC), 32'd1);
                rx_active = 1'b1;
                rx_cnt    = 0;
                rx_bits   = 0;
            end else if (rx_active) begin
                rx_cnt++;
                if (rx_cnt >= BC + BC / 2 && ((rx_cnt - BC - BC / 2) % BC) == 0) begin
                    rx_shreg = {rx_shreg[DB-2:0], txline};
                    rx_bits++;
                    if (rx_bits == DB) begin
                        rx_last   = rx_shreg;
                        rx_n++;
                        rx_active = 1'b0;
                    end
                end
            end
            if (!prev_line && txline) rise_cyc = cyc;
            if (txline) run++;
            else        run = 0;
            prev_line = txline;
        end
    end

    // Check one frame from the cycle after its accepting edge through the
    // frame_done cycle. mode 0: valid low; 1: valid held with nxt; 2: random.
    task automatic frame_body(input logic [DB-1:0] b, input int mode, input logic [DB-1:0] nxt);
        int rx_before;
        rx_before = rx_n;
        for (int k = 0; k < FLEN; k++) begin
            check("line", 32'(txline), 32'(exp_line(b, k)));
            check("busy_in_frame", 32'(busy), 32'd1);
            check("ready_in_frame", 32'(tx_ready), 32'd0);
            check("done_in_frame", 32'(frame_done), 32'd0);
            case (mode)
                0: tx_valid = 1'b0;
                1: begin tx_valid = 1'b1; tx_data = nxt; end
                default: begin
                    tx_valid = 1'($urandom_range(1));
                    tx_data  = DB'($urandom);
                end
            endcase
            tick();
        end
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("ready_at_done", 32'(tx_ready), 32'd1);
        check("line_idle_at_done", 32'(txline), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("rx_byte", 32'(rx_last), 32'(b));
        check("rx_count", rx_n, rx_before + 1);
        if (mode == 2) tx_valid = 1'b0;
    endtask

    initial begin
        int t_end;
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        gap_chk  = 1'b0;
        rx_n     = 0;
        rx_last  = '0;
        rx_shreg = '0;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;

        // 1: reset state, then a single A5 frame.
        repeat (3) tick();
        check("rst_line", 32'(txline), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_ready_in_reset", 32'(tx_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(tx_ready), 32'd1);
        repeat (12) tick();
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        frame_body(8'hA5, 0, 8'h00);

        // 2: valid held, FF then 00 back-to-back.
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick();
        frame_body(8'hFF, 1, 8'h00);
        t_end = cyc - (FLEN - (1 + DB) * BC);   // cycle where the last data bit ended
        tick();
        @(negedge clk);
        #1;
        check("b2b_gap", fall_cyc - t_end, SC + 1);
        frame_body(8'h00, 0, 8'h00);
        check("zero_low_len", rise_cyc - fall_cyc, (1 + DB) * BC);

        // 3: tx_valid/tx_data churn mid-frame must not disturb it.
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        tick();
        frame_body(8'h5A, 2, 8'h00);

        // 5: reset wins over tx_valid; accept on the first cycle after reset.
        reset    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ready_during_reset", 32'(tx_ready), 32'd0);
            tick();
            check("busy_during_reset", 32'(busy), 32'd0);
        end
        reset = 1'b0;
        #1;
        check("ready_reset_fall", 32'(tx_ready), 32'd1);
        tick();
        frame_body(8'h55, 0, 8'h00);

        // 4: reset in DATA bit 3 aborts; next 3C frame intact.
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        tx_valid = 1'b0;
        repeat (BC + 3 * BC + 1) tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        check("abort_line", 32'(txline), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("abort_no_done", 32'(frame_done), 32'd0);
            check("abort_idle_line", 32'(txline), 32'd1);
        end
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        tick();
        frame_body(8'h3C, 0, 8'h00);

        // 6: every byte value through the receiver model, back-to-back.
        gap_chk = 1'b1;
        for (int v = 0; v < 256; v++) begin
            tx_valid = 1'b1;
            tx_data  = DB'(v);
            tick();
            frame_body(DB'(v), 0, 8'h00);
        end
        gap_chk = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
